// File: rtl/icache_pkg.sv
// Shared types and sizing helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int unsigned index_width(input int unsigned sets);
    return 32'($clog2(sets));
  endfunction

  function automatic int unsigned tag_width(input int unsigned data_width,
                                            input int unsigned sets);
    return data_width - 32'd2 - 32'($clog2(sets));
  endfunction

endpackage

// File: rtl/icache_ram.sv
// Line storage: one data word and one tag per set, async read, sync write.
module icache_ram
  import icache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SETS       = 64,
  localparam int unsigned IDX_W     = index_width(SETS),
  localparam int unsigned TAG_W     = tag_width(DATA_WIDTH, SETS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [TAG_W-1:0]      wtag,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [TAG_W-1:0]      rtag
);

  logic [DATA_WIDTH-1:0] data_mem [SETS];
  logic [TAG_W-1:0]      tag_mem  [SETS];

  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[waddr] <= wdata;
      tag_mem[waddr]  <= wtag;
    end
  end

  assign rdata = data_mem[raddr];
  assign rtag  = tag_mem[raddr];

endmodule

// File: rtl/icache_fetch.sv
// Fetch-stage instruction cache: zero-latency hit path, single-word refill on miss,
// fence.i style invalidate-all that defers behind an in-flight refill.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SETS       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PC,
  input  logic                  inv,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  en_f,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid
);

  localparam int unsigned IDX_W   = index_width(SETS);
  localparam int unsigned TAG_W   = tag_width(DATA_WIDTH, SETS);
  localparam int unsigned TAG_LSB = IDX_W + 2;

  state_t                state;
  logic [SETS-1:0]       valid;
  logic                  inv_pend;
  logic [DATA_WIDTH-1:0] miss_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic [IDX_W-1:0]      pc_idx;
  logic [IDX_W-1:0]      fill_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic [TAG_W-1:0]      fill_tag;
  logic [TAG_W-1:0]      line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  hit;

  assign pc_idx   = PC[TAG_LSB-1:2];
  assign pc_tag   = PC[DATA_WIDTH-1:TAG_LSB];
  assign fill_idx = miss_addr[TAG_LSB-1:2];
  assign fill_tag = miss_addr[DATA_WIDTH-1:TAG_LSB];
  assign mem_addr = miss_addr;

  icache_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .SETS      (SETS)
  ) u_ram (
    .clk  (clk),
    .we   (state == FILL),
    .waddr(fill_idx),
    .wdata(fill_data),
    .wtag (fill_tag),
    .raddr(pc_idx),
    .rdata(line_data),
    .rtag (line_tag)
  );

  // Hit path is combinational so a resident line is delivered in the request cycle.
  always_comb begin
    hit   = (state == IDLE) && valid[pc_idx] && (line_tag == pc_tag) && !inv && !inv_pend;
    en_f  = hit;
    instr = hit ? line_data : DATA_WIDTH'(NOP_INSTR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      inv_pend  <= 1'b0;
      miss_addr <= '0;
      fill_data <= '0;
      mem_req   <= 1'b0;
    end else begin
      unique case (state)
        // Invalidate wins over a simultaneous miss; no refill starts that cycle.
        IDLE: begin
          if (inv) begin
            valid <= '0;
          end else if (!hit) begin
            miss_addr <= PC & ~DATA_WIDTH'(3);
            mem_req   <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (inv) inv_pend <= 1'b1;
          if (mem_valid) begin
            fill_data <= mem_rdata;
            mem_req   <= 1'b0;
            state     <= FILL;
          end
        end
        // A deferred invalidate also drops the line being written now.
        FILL: begin
          if (inv || inv_pend) valid <= '0;
          else                 valid[fill_idx] <= 1'b1;
          inv_pend <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: refill latency, hits, aliasing, invalidate and reset cases.
module tb_icache_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        inv;
  logic [31:0] instr;
  logic        en_f;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  int checks   = 0;
  int failures = 0;

  icache_fetch #(
    .DATA_WIDTH(32),
    .SETS      (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .PC       (pc),
    .inv      (inv),
    .instr    (instr),
    .en_f     (en_f),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Called in the miss cycle; memory answers in the n-th FETCH cycle (n >= 1).
  // PC wanders during the refill to show the latched miss address is kept.
  task automatic refill(input logic [31:0] addr, input logic [31:0] data, input int n);
    pc = addr;
    sample();
    check("miss_en_f", 32'(en_f), 32'd0);
    check("miss_instr", instr, NOP);
    step();
    for (int k = 1; k <= n; k++) begin
      pc = addr ^ 32'h0000_0ff0;
      if (k == n) begin
        mem_valid = 1'b1;
        mem_rdata = data;
      end
      sample();
      check("fetch_mem_req", 32'(mem_req), 32'd1);
      check("fetch_mem_addr", mem_addr, addr);
      check("fetch_en_f", 32'(en_f), 32'd0);
      step();
    end
    mem_valid = 1'b0;
    mem_rdata = 32'hdead_beef;
    pc        = addr;
    sample();
    check("fill_mem_req", 32'(mem_req), 32'd0);
    check("fill_en_f", 32'(en_f), 32'd0);
    step();
    sample();
    check("refill_en_f", 32'(en_f), 32'd1);
    check("refill_instr", instr, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    pc        = 32'h0;
    inv       = 1'b0;
    mem_rdata = 32'h0;
    mem_valid = 1'b0;
    step();
    step();
    sample();
    check("rst_en_f", 32'(en_f), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    step();
    rst = 1'b0;

    // First refill: memory answers in the 2nd FETCH cycle, hit 4 cycles after the miss.
    refill(32'h0000_0000, 32'h0050_0093, 2);

    // Refill 0x100, then a repeat access hits with no request issued.
    step();
    refill(32'h0000_0100, 32'h1111_0001, 3);
    step();
    sample();
    check("rehit_en_f", 32'(en_f), 32'd1);
    check("rehit_instr", instr, 32'h1111_0001);
    check("rehit_mem_req", 32'(mem_req), 32'd0);
    step();
    sample();
    check("rehit2_mem_req", 32'(mem_req), 32'd0);

    // Aliasing: 0x004 and 0x104 share index 1.
    step();
    refill(32'h0000_0004, 32'h2222_0004, 1);
    step();
    refill(32'h0000_0104, 32'h3333_0104, 2);
    step();
    refill(32'h0000_0004, 32'h4444_0004, 1);

    // Invalidate in IDLE with the line resident.
    step();
    inv = 1'b1;
    sample();
    check("inv_cycle_en_f", 32'(en_f), 32'd0);
    check("inv_cycle_instr", instr, NOP);
    step();
    inv = 1'b0;
    refill(32'h0000_0004, 32'h5555_0004, 1);
    step();
    refill(32'h0000_0100, 32'h6666_0100, 1);

    // Invalidate during FETCH of 0x200: refill completes, line still gone.
    step();
    pc = 32'h0000_0200;
    sample();
    check("inv_fetch_miss", 32'(en_f), 32'd0);
    step();
    inv = 1'b1;
    sample();
    check("inv_fetch_req", 32'(mem_req), 32'd1);
    step();
    inv       = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 32'h7777_0200;
    sample();
    check("inv_fetch_req2", 32'(mem_req), 32'd1);
    step();
    mem_valid = 1'b0;
    sample();
    check("inv_fill_en_f", 32'(en_f), 32'd0);
    step();
    refill(32'h0000_0200, 32'h8888_0200, 1);

    // Simultaneous miss and invalidate: no refill starts.
    step();
    pc  = 32'h0000_0300;
    inv = 1'b1;
    sample();
    check("miss_inv_en_f", 32'(en_f), 32'd0);
    step();
    inv = 1'b0;
    sample();
    check("miss_inv_no_req", 32'(mem_req), 32'd0);
    refill(32'h0000_0300, 32'h9999_0300, 2);

    // Reset during FETCH followed by a stale mem_valid.
    step();
    pc = 32'h0000_0400;
    sample();
    check("rst_fetch_miss", 32'(en_f), 32'd0);
    step();
    sample();
    check("rst_fetch_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    rst       = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 32'hbad0_0400;
    sample();
    check("stale_mem_req", 32'(mem_req), 32'd0);
    check("stale_en_f", 32'(en_f), 32'd0);
    check("stale_mem_addr", mem_addr, 32'h0);
    step();
    mem_valid = 1'b0;
    sample();
    check("post_rst_req", 32'(mem_req), 32'd1);
    check("post_rst_addr", mem_addr, 32'h0000_0400);
    step();
    mem_valid = 1'b1;
    mem_rdata = 32'haaaa_0400;
    step();
    mem_valid = 1'b0;
    step();
    sample();
    check("post_rst_instr", instr, 32'haaaa_0400);
    step();
    refill(32'h0000_0300, 32'hbbbb_0300, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of address, instruction and memory data.
REQ-002 Parameter: SETS, 64, number of direct-mapped one-word lines (power of 2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 PC  in  DATA_WIDTH  fetch address from the PC stage (word-aligned; bits [1:0] ignored).
REQ-006 inv  in  1  invalidate-all request (fence.i), one-cycle pulse.
REQ-007 instr  out  DATA_WIDTH  fetched instruction for the IF/ID register.
REQ-008 en_f  out  1  fetch enable to PC stage; 1 = instr valid and PC may advance.
REQ-009 mem_req  out  1  refill request to backing memory.
REQ-010 mem_addr  out  DATA_WIDTH  word-aligned refill address.
REQ-011 mem_rdata  in  DATA_WIDTH  refill data.
REQ-012 mem_valid  in  1  refill data valid, one-cycle pulse.

Function
REQ-013 Address split SHALL be: index = PC[2+log2(SETS)-1:2], tag = PC[DATA_WIDTH-1:2+log2(SETS)].
REQ-014 Hit SHALL be combinational: state IDLE and valid[index] and tag_ram[index]==tag, with no inv pending.
REQ-015 On hit, instr SHALL equal data_ram[index] and en_f SHALL be 1 in the same cycle (zero-latency read).
REQ-016 When en_f is 0, instr SHALL be the NOP constant 0x00000013.
REQ-017 FSM states SHALL be IDLE, FETCH, FILL.
REQ-018 IDLE -> FETCH on miss; miss address (PC with [1:0]=0) SHALL be latched into miss_addr.
REQ-019 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal miss_addr, both stable until mem_valid.
REQ-020 FETCH -> FILL on mem_valid; mem_rdata SHALL be captured that edge; mem_valid outside FETCH SHALL be ignored.
REQ-021 In FILL, data and tag SHALL be written at miss_addr index, valid set to 1, then -> IDLE; mem_req 0.
REQ-022 Miss penalty: with mem_valid N cycles after FETCH entry, en_f SHALL rise N+2 cycles after the miss cycle.
REQ-023 PC changes while not IDLE SHALL not affect miss_addr; after FILL, current PC is re-evaluated in IDLE.
REQ-024 inv in IDLE SHALL clear all valid bits at the next edge; en_f SHALL be 0 in the inv cycle.
REQ-025 inv in FETCH or FILL SHALL set inv_pend; the refill completes, then all valid bits (including the filled line) SHALL be cleared on the FILL->IDLE edge; inv_pend cleared.
REQ-026 Simultaneous miss and inv in IDLE: invalidate SHALL take priority; no refill starts that cycle.
REQ-027 Index aliasing: a refill SHALL overwrite the resident line unconditionally (no write-back; read-only cache).

Reset
REQ-028 rst SHALL force state IDLE, all valid bits 0, inv_pend 0, miss_addr 0, mem_req 0.
REQ-029 After reset, en_f SHALL be 0 and instr NOP until the first refill completes.
REQ-030 rst mid-refill SHALL abandon it; a mem_valid arriving afterwards SHALL be ignored.
REQ-031 Data and tag arrays need not be reset.

Structure
REQ-032 Package icache_pkg SHALL hold the state enum, NOP constant, and index/tag width functions of SETS.
REQ-033 Storage SHALL be one sub-module icache_ram (async read, sync write, data+tag); valid bits and FSM stay in icache_fetch.
REQ-034 Target size 120-400 lines RTL total.

Verification
REQ-035 Reset, PC=0x00000000, mem_valid 2 cycles after mem_req with 0x00500093 -> mem_addr=0x0, en_f=1 and instr=0x00500093 four cycles after the miss cycle.
REQ-036 Refill 0x100 then PC=0x100 again -> en_f=1 same cycle, mem_req stays 0.
REQ-037 Line at 0x004 filled, PC=0x104 (same index, different tag) -> miss, mem_addr=0x104, line replaced; subsequent PC=0x004 misses.
REQ-038 inv pulse in IDLE with line valid -> next access to that PC misses; en_f=0 during inv cycle.
REQ-039 inv during FETCH for 0x200 -> refill completes, then access to 0x200 misses again.
REQ-040 rst asserted in FETCH, stale mem_valid one cycle after -> state IDLE, no line valid, en_f=0.
